dp_vector_feeder: RTL and testbench

- Front-end driver for the 8-lane dot-product engines; the initiator side of their vec_a/vec_b/compute -> dot_product/out_valid interface.
- Accepts a serial stream of (a,b) element pairs over a valid/ready handshake and packs N_ELEM pairs into vec_a/vec_b lanes.
- Issues a one-cycle compute pulse, then captures the engine result DP_LATENCY cycles later.
- Presents the result downstream on a valid/ready handshake with an error flag and a completed-vector counter.

---
 rtl/dp_vector_feeder.sv | 116 +++++++++++
 tb/tb_dp_vector_feeder.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/dp_vector_feeder.sv
// Initiator for the 8-lane dot-product engine: packs streamed (a,b) pairs into lanes,
// pulses compute, captures the engine result and hands it downstream.
//
//   state | meaning
//   FILL  | accepting pairs into lanes, in_ready high
//   FIRE  | one-cycle compute pulse, vectors held
//   WAIT  | counting engine latency, result captured on last cycle
//   OUT   | result presented until downstream handshake
module dp_vector_feeder #(
  parameter int N_ELEM     = 8,
  parameter int ELEM_W     = 8,
  parameter int RES_W      = 19,
  parameter int DP_LATENCY = 2,
  parameter int CNT_W      = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     i_in_valid,
  output logic                     o_in_ready,
  input  logic [ELEM_W-1:0]        i_in_a,
  input  logic [ELEM_W-1:0]        i_in_b,
  output logic [N_ELEM*ELEM_W-1:0] o_vec_a,
  output logic [N_ELEM*ELEM_W-1:0] o_vec_b,
  output logic                     o_compute,
  input  logic [RES_W-1:0]         i_dp_result,
  input  logic                     i_dp_valid,
  output logic                     o_res_valid,
  input  logic                     i_res_ready,
  output logic [RES_W-1:0]         o_res_data,
  output logic                     o_res_err,
  output logic [CNT_W-1:0]         o_vec_count
);

  localparam int IDX_W  = (N_ELEM > 1) ? $clog2(N_ELEM) : 1;
  localparam int WCNT_W = $clog2(DP_LATENCY + 1);

  typedef enum logic [1:0] {FILL, FIRE, WAIT, OUT} state_t;

  state_t                          r_state;
  logic [IDX_W-1:0]                r_idx;
  logic [WCNT_W-1:0]               r_wait_cnt;
  logic [N_ELEM-1:0][ELEM_W-1:0]   r_vec_a;
  logic [N_ELEM-1:0][ELEM_W-1:0]   r_vec_b;
  logic                            r_compute;
  logic                            r_res_valid;
  logic [RES_W-1:0]                r_res_data;
  logic                            r_res_err;
  logic [CNT_W-1:0]                r_vec_count;
  logic                            w_accept;

  assign o_in_ready  = (r_state == FILL);
  assign w_accept    = i_in_valid && o_in_ready;
  assign o_vec_a     = r_vec_a;
  assign o_vec_b     = r_vec_b;
  assign o_compute   = r_compute;
  assign o_res_valid = r_res_valid;
  assign o_res_data  = r_res_data;
  assign o_res_err   = r_res_err;
  assign o_vec_count = r_vec_count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= FILL;
      r_idx       <= '0;
      r_wait_cnt  <= '0;
      r_vec_a     <= '0;
      r_vec_b     <= '0;
      r_compute   <= 1'b0;
      r_res_valid <= 1'b0;
      r_res_data  <= '0;
      r_res_err   <= 1'b0;
      r_vec_count <= '0;
    end else begin
      r_compute <= 1'b0;
      case (r_state)
        FILL: begin
          if (w_accept) begin
            r_vec_a[r_idx] <= i_in_a;
            r_vec_b[r_idx] <= i_in_b;
            if (r_idx == IDX_W'(N_ELEM - 1)) begin
              r_idx     <= '0;
              r_state   <= FIRE;
              r_compute <= 1'b1;
            end else begin
              r_idx <= r_idx + IDX_W'(1);
            end
          end
        end
        FIRE: begin
          r_state    <= WAIT;
          r_wait_cnt <= WCNT_W'(1);
        end
        WAIT: begin
          // dp_valid matters only on the final latency cycle
          if (r_wait_cnt == WCNT_W'(DP_LATENCY)) begin
            r_res_data  <= i_dp_result;
            r_res_err   <= ~i_dp_valid;
            r_res_valid <= 1'b1;
            r_state     <= OUT;
          end else begin
            r_wait_cnt <= r_wait_cnt + WCNT_W'(1);
          end
        end
        OUT: begin
          if (i_res_ready) begin
            r_res_valid <= 1'b0;
            r_vec_count <= r_vec_count + CNT_W'(1);
            r_state     <= FILL;
          end
        end
        default: r_state <= FILL;
      endcase
    end
  end

endmodule

// File: tb/tb_dp_vector_feeder.sv
// Scoreboard bench for dp_vector_feeder: reference sums from the issued pairs, engine stub
// computing from the presented lanes, monitor popping expectations on result handshakes.
module tb_dp_vector_feeder;

  localparam int N   = 8;
  localparam int EW  = 8;
  localparam int RW  = 19;
  localparam int LAT = 2;
  localparam int CW  = 16;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            i_in_valid = 1'b0;
  logic            o_in_ready;
  logic [EW-1:0]   i_in_a = '0;
  logic [EW-1:0]   i_in_b = '0;
  logic [N*EW-1:0] o_vec_a;
  logic [N*EW-1:0] o_vec_b;
  logic            o_compute;
  logic [RW-1:0]   i_dp_result;
  logic            i_dp_valid;
  logic            o_res_valid;
  logic            i_res_ready = 1'b0;
  logic [RW-1:0]   o_res_data;
  logic            o_res_err;
  logic [CW-1:0]   o_vec_count;

  dp_vector_feeder #(.N_ELEM(N), .ELEM_W(EW), .RES_W(RW), .DP_LATENCY(LAT), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n),
    .i_in_valid(i_in_valid), .o_in_ready(o_in_ready), .i_in_a(i_in_a), .i_in_b(i_in_b),
    .o_vec_a(o_vec_a), .o_vec_b(o_vec_b), .o_compute(o_compute),
    .i_dp_result(i_dp_result), .i_dp_valid(i_dp_valid),
    .o_res_valid(o_res_valid), .i_res_ready(i_res_ready), .o_res_data(o_res_data),
    .o_res_err(o_res_err), .o_vec_count(o_vec_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [RW-1:0] data;
    logic          err;
  } exp_t;

  exp_t  sb_q[$];
  int    n_cmp = 0;
  int    n_bad = 0;
  int    exp_count = 0;
  int    ready_mode = 0;   // 0 random, 1 hold low, 2 hold high
  logic  err_next = 1'b0;
  logic [EW-1:0] va[N];
  logic [EW-1:0] vb[N];

  function automatic void check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, req, $time);
    end
  endfunction

  // Engine stub: result for the lanes seen at compute, valid only in the capture cycle
  initial begin : engine_stub
    int s;
    i_dp_result = '0;
    i_dp_valid  = 1'b0;
    forever begin
      @(posedge clk); #1;
      if (rst_n && o_compute) begin
        s = 0;
        for (int i = 0; i < N; i++)
          s += int'(o_vec_a[i*EW +: EW]) * int'(o_vec_b[i*EW +: EW]);
        repeat (LAT) @(posedge clk);
        #1;
        i_dp_result = err_next ? RW'(20'h12345) : RW'(s);
        i_dp_valid  = !err_next;
        @(posedge clk); #1;
        i_dp_result = RW'($urandom);
        i_dp_valid  = 1'b0;
      end
    end
  end

  initial begin : ready_driver
    forever begin
      @(posedge clk); #1;
      case (ready_mode)
        1:       i_res_ready = 1'b0;
        2:       i_res_ready = 1'b1;
        default: i_res_ready = 1'($urandom);
      endcase
    end
  end

  initial begin : monitor
    exp_t e;
    logic prev_compute;
    prev_compute = 1'b0;
    forever begin
      @(negedge clk);
      if (o_compute) check("compute_single_cycle", 64'(prev_compute), 0);
      prev_compute = o_compute;
      if (rst_n && o_res_valid && i_res_ready) begin
        if (sb_q.size() == 0) begin
          check("unexpected_result", 1, 0);
        end else begin
          e = sb_q.pop_front();
          check("res_data", 64'(o_res_data), 64'(e.data));
          check("res_err", 64'(o_res_err), 64'(e.err));
          check("vec_count_at_handshake", 64'(o_vec_count), 64'(exp_count % 65536));
          exp_count++;
        end
      end
    end
  end

  task automatic send_pair(input logic [EW-1:0] a, input logic [EW-1:0] b);
    int t = 0;
    i_in_valid = 1'b1;
    i_in_a = a;
    i_in_b = b;
    while (!o_in_ready && t < 500) begin
      @(posedge clk); #1;
      t++;
    end
    if (!o_in_ready) check("in_ready_timeout", 0, 1);
    @(posedge clk); #1;
    i_in_valid = 1'b0;
    i_in_a = EW'($urandom);
    i_in_b = EW'($urandom);
  endtask

  // Returns in the first cycle the result is presented
  task automatic send_vector(input bit err, input int gap_pct);
    exp_t e;
    int s = 0;
    logic [N*EW-1:0] pa, pb;
    for (int i = 0; i < N; i++) begin
      s += int'(va[i]) * int'(vb[i]);
      pa[i*EW +: EW] = va[i];
      pb[i*EW +: EW] = vb[i];
    end
    e.data = err ? RW'(20'h12345) : RW'(s);
    e.err  = err;
    sb_q.push_back(e);
    err_next = err;
    for (int i = 0; i < N; i++) begin
      if (int'($urandom_range(99)) < gap_pct) begin
        i_in_valid = 1'b0;
        i_in_a = EW'($urandom);
        i_in_b = EW'($urandom);
        repeat ($urandom_range(1, 3)) @(posedge clk);
        #1;
      end
      send_pair(va[i], vb[i]);
    end
    check("compute_after_last_accept", 64'(o_compute), 1);
    check("in_ready_in_fire", 64'(o_in_ready), 0);
    check("vec_a", 64'(o_vec_a), 64'(pa));
    check("vec_b", 64'(o_vec_b), 64'(pb));
    for (int k = 1; k <= LAT; k++) begin
      @(posedge clk); #1;
      if (o_compute || o_res_valid) check("wait_phase_quiet", {62'd0, o_compute, o_res_valid}, 0);
    end
    @(posedge clk); #1;
    check("res_valid_latency", 64'(o_res_valid), 1);
  endtask

  task automatic wait_drain();
    int t = 0;
    while (sb_q.size() > 0 && t < 2000) begin
      @(posedge clk); #1;
      t++;
    end
    if (sb_q.size() > 0) check("drain_timeout", 64'(sb_q.size()), 0);
    @(posedge clk); #1;
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_in_ready"}, 64'(o_in_ready), 1);
    check({tag, "_vec_a"}, 64'(o_vec_a), 0);
    check({tag, "_vec_b"}, 64'(o_vec_b), 0);
    check({tag, "_compute"}, 64'(o_compute), 0);
    check({tag, "_res_valid"}, 64'(o_res_valid), 0);
    check({tag, "_res_data"}, 64'(o_res_data), 0);
    check({tag, "_res_err"}, 64'(o_res_err), 0);
    check({tag, "_vec_count"}, 64'(o_vec_count), 0);
  endtask

  initial begin : stimulus
    logic [RW-1:0] held;
    #12;
    check_reset_values("por");
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Ascending a, b=1
    ready_mode = 2;
    for (int i = 0; i < N; i++) begin va[i] = EW'(i + 1); vb[i] = 8'd1; end
    send_vector(1'b0, 0);
    check("first_res_data", 64'(o_res_data), 36);
    @(posedge clk); #1;
    check("first_vec_count", 64'(o_vec_count), 1);

    // All max
    for (int i = 0; i < N; i++) begin va[i] = 8'hFF; vb[i] = 8'hFF; end
    send_vector(1'b0, 0);
    check("max_res_data", 64'(o_res_data), 520200);

    // Gapped fill
    for (int i = 0; i < N; i++) begin va[i] = 8'd2; vb[i] = 8'd3; end
    send_vector(1'b0, 60);
    check("gap_res_data", 64'(o_res_data), 48);
    wait_drain();

    // Downstream stall
    ready_mode = 1;
    @(posedge clk); #1;
    for (int i = 0; i < N; i++) begin va[i] = EW'($urandom); vb[i] = EW'($urandom); end
    send_vector(1'b0, 20);
    held = o_res_data;
    check("stall_data_model", 64'(held), 64'(sb_q[0].data));
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      check("stall_res_valid", 64'(o_res_valid), 1);
      check("stall_res_data", 64'(o_res_data), 64'(sb_q[0].data));
      check("stall_in_ready", 64'(o_in_ready), 0);
      check("stall_compute", 64'(o_compute), 0);
      check("stall_vec_count", 64'(o_vec_count), 64'(exp_count));
    end
    ready_mode = 2;
    wait_drain();

    // Engine reports invalid, then a valid one
    for (int i = 0; i < N; i++) begin va[i] = EW'($urandom); vb[i] = EW'($urandom); end
    send_vector(1'b1, 0);
    for (int i = 0; i < N; i++) begin va[i] = EW'($urandom); vb[i] = EW'($urandom); end
    send_vector(1'b0, 0);

    // Random traffic
    ready_mode = 0;
    for (int v = 0; v < 10; v++) begin
      for (int i = 0; i < N; i++) begin va[i] = EW'($urandom); vb[i] = EW'($urandom); end
      send_vector(1'b0, 30);
    end
    wait_drain();

    // Reset mid-fill
    ready_mode = 2;
    for (int i = 0; i < 5; i++) send_pair(EW'($urandom_range(1, 255)), EW'($urandom_range(1, 255)));
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_values("midrst");
    exp_count = 0;
    @(posedge clk); #1;
    check_reset_values("midrst_hold");
    rst_n = 1'b1;
    for (int i = 0; i < N; i++) begin va[i] = EW'(i + 1); vb[i] = EW'(N - i); end
    send_vector(1'b0, 0);
    check("post_reset_res_data", 64'(o_res_data), 120);
    for (int v = 0; v < 2; v++) begin
      for (int i = 0; i < N; i++) begin va[i] = EW'($urandom); vb[i] = EW'($urandom); end
      send_vector(1'b0, 0);
    end
    wait_drain();
    check("final_vec_count", 64'(o_vec_count), 3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
